// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and pointer-code helpers for the asynchronous FIFO
//
// Purpose : default FIFO geometry and the binary/Gray conversions used by both
//           the read-side and write-side pointer blocks.
// Contents: FIFO_ASIZE, FIFO_DSIZE  default address / data widths
//           PTR_MAXW, ptr_t         widest pointer the helpers accept
//           bin2gray(bin, width)    Gray code of the low `width` bits of bin
//           gray2bin(gray, width)   binary value of the low `width` bits of gray
// Callers size-cast the arguments and result to their own pointer width.
package fifo_pkg;

  localparam int FIFO_ASIZE = 5;
  localparam int FIFO_DSIZE = 8;

  localparam int PTR_MAXW = 32;
  typedef logic [PTR_MAXW-1:0] ptr_t;

  // Ones in bit positions [width-1:0], zeros above.
  function automatic ptr_t width_mask(input int width);
    ptr_t m;
    for (int i = 0; i < PTR_MAXW; i++) begin
      m[i] = (i < width);
    end
    return m;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t bin, input int width);
    ptr_t b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; bits above `width` are cleared first so
  // they contribute nothing to the running parity.
  function automatic ptr_t gray2bin(input ptr_t gray, input int width);
    ptr_t g;
    ptr_t b;
    g = gray & width_mask(width);
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// rtl/fifo_rd_outreg.sv - registered valid/ready output stage of the FIFO read port
//
// Purpose: decides when a word leaves the FIFO memory and holds it in a
//          registered output stage until the consumer accepts it.
// Ports  : i_clk       read-domain clock
//          i_rst       synchronous active-high reset
//          i_rempty    memory holds no unread word
//          i_rdata     memory word at the current read address
//          i_rd_ready  consumer accepts o_rd_data this cycle
//          o_pop       a word is taken from memory on this edge
//          o_rd_valid  o_rd_data holds a valid word
//          o_rd_data   registered output word
module fifo_rd_outreg
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rempty,
  input  logic [DSIZE-1:0] i_rdata,
  input  logic             i_rd_ready,
  output logic             o_pop,
  output logic             o_rd_valid,
  output logic [DSIZE-1:0] o_rd_data
);

  logic             r_valid;
  logic [DSIZE-1:0] r_data;
  logic             w_pop;

  // Load whenever the stage is empty or is being emptied this cycle, which
  // gives one word per clock under continuous ready.
  assign w_pop = !i_rempty && (!r_valid || i_rd_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= i_rdata;
    end else if (r_valid && i_rd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_pop      = w_pop;
  assign o_rd_valid = r_valid;
  assign o_rd_data  = r_data;

endmodule

// File: rtl/fifo_rd_port.sv
// rtl/fifo_rd_port.sv - read-domain pointer, empty flag and FWFT output of the async FIFO
//
// Purpose : owns the binary and Gray read pointers, addresses the FIFO memory,
//           derives the empty flag from the synchronized write pointer and
//           presents words through a first-word-fall-through output stage.
// Optional: FIFO_RD_OCCUPANCY_EN adds the registered rcount output.
// Ports   : rclk      read-domain clock
//           rrst      synchronous active-high reset
//           rq2_wptr  write Gray pointer, already synchronized into rclk
//           rdata     memory read data, combinational from raddr
//           raddr     memory read address
//           rptr      registered read Gray pointer for the write domain
//           rempty    memory holds no unread word
//           rd_valid  rd_data holds a valid word
//           rd_ready  consumer accepts rd_data this cycle
//           rd_data   registered output word
//           rcount    unread words in memory, output word excluded (optional)
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int ASIZE = FIFO_ASIZE,
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0] rdata,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DSIZE-1:0] rd_data
`ifdef FIFO_RD_OCCUPANCY_EN
  ,
  output logic [ASIZE:0]   rcount
`endif
);

  logic [ASIZE:0] r_rbin;
  logic [ASIZE:0] r_rptr;
  logic           r_rempty;

  logic           w_pop;
  logic [ASIZE:0] w_rbinnext;
  logic [ASIZE:0] w_rgraynext;

  fifo_rd_outreg #(
    .DSIZE (DSIZE)
  ) u_outreg (
    .i_clk      (rclk),
    .i_rst      (rrst),
    .i_rempty   (r_rempty),
    .i_rdata    (rdata),
    .i_rd_ready (rd_ready),
    .o_pop      (w_pop),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data)
  );

  // The extra MSB distinguishes full from empty on the write side; the add
  // wraps naturally modulo 2**(ASIZE+1).
  assign w_rbinnext  = r_rbin + {{ASIZE{1'b0}}, w_pop};
  assign w_rgraynext = (ASIZE+1)'(bin2gray(PTR_MAXW'(w_rbinnext), ASIZE + 1));

  // Empty is computed from the post-pop pointer, so the flag rises on the
  // same edge that moves the last word into the output stage. A stale
  // rq2_wptr lags the true write pointer and can only report empty early.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbinnext;
      r_rptr   <= w_rgraynext;
      r_rempty <= (w_rgraynext == rq2_wptr);
    end
  end

  assign raddr  = r_rbin[ASIZE-1:0];
  assign rptr   = r_rptr;
  assign rempty = r_rempty;

`ifdef FIFO_RD_OCCUPANCY_EN
  logic [ASIZE:0] w_wbin;
  logic [ASIZE:0] r_rcount;

  assign w_wbin = (ASIZE+1)'(gray2bin(PTR_MAXW'(rq2_wptr), ASIZE + 1));

  // Measured against the post-pop pointer so that a word moving into the
  // output stage is no longer counted, and rcount == 0 exactly when rempty.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rcount <= '0;
    end else begin
      r_rcount <= w_wbin - w_rbinnext;
    end
  end

  assign rcount = r_rcount;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// tb/tb_fifo_rd_port.sv - self-checking bench for fifo_rd_port with a queue reference model
`timescale 1ns/1ps
module tb_fifo_rd_port;

  localparam int ASIZE = 2;
  localparam int DSIZE = 8;
  localparam int DEPTH = 4;

  logic             rclk = 1'b0;
  logic             rrst;
  logic [ASIZE:0]   rq2_wptr;
  logic [DSIZE-1:0] rdata;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic             rempty;
  logic             rd_valid;
  logic             rd_ready;
  logic [DSIZE-1:0] rd_data;
`ifdef FIFO_RD_OCCUPANCY_EN
  logic [ASIZE:0]   rcount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wbin;
  int               written;
  int               consumed;
  bit               trace_en;
  logic [DSIZE-1:0] exp_q[$];
  logic [DSIZE-1:0] got_q[$];
  logic [ASIZE-1:0] raddr_tr[$];
  logic [ASIZE:0]   rptr_tr[$];

  always #5 rclk = ~rclk;

  assign rdata = mem[raddr];

  fifo_rd_port #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rq2_wptr (rq2_wptr),
    .rdata    (rdata),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data)
`ifdef FIFO_RD_OCCUPANCY_EN
    ,
    .rcount   (rcount)
`endif
  );

  function automatic logic [ASIZE:0] gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  // Write side stand-in: store the word, then advance the synchronized pointer.
  task automatic push(input logic [DSIZE-1:0] d);
    mem[wbin[ASIZE-1:0]] = d;
    exp_q.push_back(d);
    wbin     = wbin + 3'd1;
    rq2_wptr = gray(wbin);
    written++;
  endtask

  // Record what the consumer takes at the coming edge, then advance one clock.
  task automatic cycle();
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      got_q.push_back(rd_data);
      consumed++;
    end
    if (trace_en && (raddr_tr.size() == 0 || raddr_tr[raddr_tr.size()-1] !== raddr)) begin
      raddr_tr.push_back(raddr);
      rptr_tr.push_back(rptr);
    end
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst     = 1'b1;
    rd_ready = 1'b0;
    wbin     = '0;
    rq2_wptr = '0;
    written  = 0;
    consumed = 0;
    trace_en = 1'b0;
    exp_q.delete();
    got_q.delete();
    raddr_tr.delete();
    rptr_tr.delete();
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (raddr !== 2'd0) begin n_fail++; $display("FAIL reset_raddr: got %0d expected 0", raddr); end
    n_checks++; if (rptr !== 3'd0) begin n_fail++; $display("FAIL reset_rptr: got %b expected 000", rptr); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
`ifdef FIFO_RD_OCCUPANCY_EN
    n_checks++; if (rcount !== 3'd0) begin n_fail++; $display("FAIL reset_rcount: got %0d expected 0", rcount); end
`endif
  endtask

  task automatic test_fwft();
    do_reset();
    push(8'hA5);
    cycle();
    n_checks++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL fwft_rempty_fall: got %b expected 0", rempty); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_valid_early: got %b expected 0", rd_valid); end
    cycle();
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_valid: got %b expected 1", rd_valid); end
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL fwft_data: got %h expected a5", rd_data); end
    n_checks++; if (rptr !== 3'b001) begin n_fail++; $display("FAIL fwft_rptr: got %b expected 001", rptr); end
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL fwft_rempty_last: got %b expected 1", rempty); end
    rd_ready = 1'b1;
    cycle();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_valid_drop: got %b expected 0", rd_valid); end
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL fwft_count: got %0d expected 1", got_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DSIZE-1:0] w [4];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w[k] = 8'($urandom);
      push(w[k]);
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== w[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, rd_valid, rd_data, w[0]); end
      n_checks++; if (rptr !== 3'b001) begin n_fail++; $display("FAIL bp_rptr[%0d]: got %b expected 001", k, rptr); end
      cycle();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== w[k]) begin n_fail++; $display("FAIL bp_stream[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, rd_valid, rd_data, w[k]); end
      n_checks++; if (rempty !== (k == 3)) begin n_fail++; $display("FAIL bp_rempty[%0d]: got %b expected %b", k, rempty, (k == 3)); end
      cycle();
    end
    n_checks++; if (rd_valid !== 1'b0 || rempty !== 1'b1) begin n_fail++; $display("FAIL bp_drained: got valid=%b rempty=%b expected valid=0 rempty=1", rd_valid, rempty); end
  endtask

  task automatic test_wrap();
    do_reset();
    trace_en = 1'b1;
    rd_ready = 1'b1;
    for (int c = 0; c < 200 && consumed < 10; c++) begin
      if (written < 10 && written - consumed < DEPTH && $urandom_range(0, 3) != 0) push(8'($urandom));
      cycle();
    end
    n_checks++; if (consumed != 10) begin n_fail++; $display("FAIL wrap_timeout: got %0d words expected 10", consumed); end
    cycle();
    cycle();
    n_checks++; if (raddr_tr.size() != 11) begin n_fail++; $display("FAIL wrap_trace_len: got %0d expected 11", raddr_tr.size()); end
    for (int i = 0; i < 11 && i < raddr_tr.size(); i++) begin
      n_checks++; if (raddr_tr[i] !== 2'(i % DEPTH)) begin n_fail++; $display("FAIL wrap_raddr[%0d]: got %0d expected %0d", i, raddr_tr[i], i % DEPTH); end
      n_checks++; if (rptr_tr[i] !== gray(3'(i % 8))) begin n_fail++; $display("FAIL wrap_rptr[%0d]: got %b expected %b", i, rptr_tr[i], gray(3'(i % 8))); end
    end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (rptr !== 3'b011 || raddr !== 2'd2 || rempty !== 1'b1) begin n_fail++; $display("FAIL wrap_final: got rptr=%b raddr=%0d rempty=%b expected 011 2 1", rptr, raddr, rempty); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(8'($urandom));
      cycle();
    end
    rd_ready = 1'b1;
    cycle();
    cycle();
    rd_ready = 1'b0;
    cycle();
    n_checks++; if (rd_valid !== 1'b1 || raddr !== 2'd3) begin n_fail++; $display("FAIL midrst_pre: got valid=%b raddr=%0d expected 1 3", rd_valid, raddr); end
    rrst     = 1'b1;
    wbin     = '0;
    rq2_wptr = '0;
    cycle();
    rrst = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", rd_valid); end
    n_checks++; if (raddr !== 2'd0 || rptr !== 3'd0) begin n_fail++; $display("FAIL midrst_ptr: got raddr=%0d rptr=%b expected 0 000", raddr, rptr); end
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL midrst_rempty: got %b expected 1", rempty); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", rd_data); end
  endtask

  task automatic test_random();
    bit               prev_hold;
    logic [DSIZE-1:0] prev_data;
    do_reset();
    prev_hold = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 400; c++) begin
      rd_ready = 1'($urandom_range(0, 1));
      if (written - consumed < DEPTH && $urandom_range(0, 1) == 1) push(8'($urandom));
      if (prev_hold) begin
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== prev_data) begin n_fail++; $display("FAIL rand_stable@%0d: got valid=%b data=%h expected valid=1 data=%h", c, rd_valid, rd_data, prev_data); end
      end
      if (rd_valid === 1'b1) begin
        n_checks++; if (consumed >= exp_q.size() || rd_data !== exp_q[consumed]) begin n_fail++; $display("FAIL rand_data@%0d: got %h expected word #%0d of %0d", c, rd_data, consumed, exp_q.size()); end
      end
      prev_hold = (rd_valid === 1'b1) && !rd_ready;
      prev_data = rd_data;
      cycle();
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 50 && consumed < written; c++) begin
      if (rd_valid === 1'b1) begin
        n_checks++; if (consumed >= exp_q.size() || rd_data !== exp_q[consumed]) begin n_fail++; $display("FAIL drain_data@%0d: got %h expected word #%0d", c, rd_data, consumed); end
      end
      cycle();
    end
    n_checks++; if (consumed != written) begin n_fail++; $display("FAIL drain_timeout: got %0d words expected %0d", consumed, written); end
    cycle();
    n_checks++; if (rd_valid !== 1'b0 || rempty !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got valid=%b rempty=%b expected 0 1", rd_valid, rempty); end
    n_checks++; if (rptr !== gray(3'(written % 8)) || raddr !== 2'(written % DEPTH)) begin n_fail++; $display("FAIL drain_ptr: got rptr=%b raddr=%0d expected %b %0d", rptr, raddr, gray(3'(written % 8)), written % DEPTH); end
  endtask

`ifdef FIFO_RD_OCCUPANCY_EN
  task automatic test_occupancy();
    do_reset();
    for (int k = 0; k < 4; k++) push(8'($urandom));
    cycle();
    n_checks++; if (rcount !== 3'd4) begin n_fail++; $display("FAIL occ_full: got %0d expected 4", rcount); end
    cycle();
    n_checks++; if (rcount !== 3'd3) begin n_fail++; $display("FAIL occ_after_pop: got %0d expected 3", rcount); end
    push(8'($urandom));
    cycle();
    n_checks++; if (rcount !== 3'd4) begin n_fail++; $display("FAIL occ_wptr5_rbin1: got %0d expected 4", rcount); end
  endtask
`endif

  initial begin
    rrst     = 1'b1;
    rd_ready = 1'b0;
    wbin     = '0;
    rq2_wptr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge rclk);
    test_reset();
    test_fwft();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_random();
`ifdef FIFO_RD_OCCUPANCY_EN
    test_occupancy();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
